// File: rtl/ro_crp_pkg.sv
// Shared definitions for the RO PUF challenge/response sequencer: FSM state
// encodings, LFSR taps, default seed and parameter defaults.
package ro_crp_pkg;

    localparam int          CHAL_W_DEF    = 34;
    localparam int          RESP_BITS_DEF = 32;
    localparam logic [33:0] DEF_SEED_DEF  = 34'h2_5A5A_5A5A;

    // x^34 + x^27 + x^2 + x + 1 -> feedback from bits 33, 26, 1 and 0
    localparam logic [33:0] LFSR_TAPS = 34'h2_0400_0003;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PRST   = 3'd1;
    localparam state_t ST_MEAS   = 3'd2;
    localparam state_t ST_SAMPLE = 3'd3;
    localparam state_t ST_OUT    = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/crp_lfsr.sv
// Fibonacci LFSR generating PUF challenges; a zero load value selects SEED so
// the register can never lock up at all-zeros.
module crp_lfsr
    import ro_crp_pkg::*;
#(
    parameter int           W    = CHAL_W_DEF,
    parameter logic [W-1:0] SEED = W'(DEF_SEED_DEF),
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         advance,
    output logic [W-1:0] value
);

    // Load has priority over advance; shift toward the MSB, feedback into bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            value <= (load_value == W'(0)) ? SEED : load_value;
        end else if (advance) begin
            value <= {value[W-2:0], ^(value & TAPS)};
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/ro_crp_sequencer.sv
// Drives an RO PUF array through reset/enable/sample phases and packs one
// response bit per challenge into resp_word. Option: RO_CRP_MAJORITY_VOTE_EN.
module ro_crp_sequencer
    import ro_crp_pkg::*;
#(
    parameter int                CHAL_W      = CHAL_W_DEF,
    parameter int                RESP_BITS   = RESP_BITS_DEF,
    parameter int                MEAS_CYCLES = 1024,
    parameter int                RST_CYCLES  = 4,
    parameter logic [CHAL_W-1:0] DEF_SEED    = CHAL_W'(DEF_SEED_DEF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [CHAL_W-1:0]    seed,
    output logic [CHAL_W-1:0]    chal,
    output logic                 puf_reset,
    output logic                 puf_enable,
    input  logic                 puf_resp,
    output logic [RESP_BITS-1:0] resp_word,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int CNT_MAX = (MEAS_CYCLES > RST_CYCLES) ?
                             ((MEAS_CYCLES > 3) ? MEAS_CYCLES : 3) :
                             ((RST_CYCLES > 3) ? RST_CYCLES : 3);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] SMP_LAST  = CNT_W'(2);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(RESP_BITS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             sync1;
    logic             sync2;
    logic             sample_done;
    logic             last_meas;
    logic             bit_done;
    logic             bit_val;

    assign sample_done = (state == ST_SAMPLE) && (cnt == SMP_LAST);
    assign bit_done    = sample_done && last_meas;

`ifdef RO_CRP_MAJORITY_VOTE_EN
    logic [1:0] meas_idx;
    logic [1:0] votes;

    assign last_meas = (meas_idx == 2'd2);
    assign bit_val   = maj3(votes[0], votes[1], sync2);

    // Track which of the three measurements is running and keep the first two results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_idx <= 2'd0;
            votes    <= 2'b00;
        end else if (state == ST_IDLE) begin
            meas_idx <= 2'd0;
            votes    <= 2'b00;
        end else if (sample_done) begin
            meas_idx <= last_meas ? 2'd0 : meas_idx + 2'd1;
            if (!last_meas) begin
                votes[meas_idx[0]] <= sync2;
            end else begin
                votes <= votes;
            end
        end else begin
            meas_idx <= meas_idx;
            votes    <= votes;
        end
    end
`else
    assign last_meas = 1'b1;
    assign bit_val   = sync2;
`endif

    // puf_resp comes from free-running oscillators, so resynchronise it first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= puf_resp;
            sync2 <= sync1;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_PRST;
                else       state_next = ST_IDLE;
            end
            ST_PRST: begin
                if (cnt == RST_LAST) state_next = ST_MEAS;
                else                 state_next = ST_PRST;
            end
            ST_MEAS: begin
                if (cnt == MEAS_LAST) state_next = ST_SAMPLE;
                else                  state_next = ST_MEAS;
            end
            ST_SAMPLE: begin
                if (!sample_done)                         state_next = ST_SAMPLE;
                else if (last_meas && bit_idx == LAST_BIT) state_next = ST_OUT;
                else                                      state_next = ST_PRST;
            end
            ST_OUT: begin
                if (resp_valid && resp_ready) state_next = ST_IDLE;
                else                          state_next = ST_OUT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, phase counter and bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == ST_IDLE || state == ST_OUT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_IDLE) begin
                bit_idx <= '0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end else begin
                bit_idx <= bit_idx;
            end
        end
    end

    // Outputs are registered from the next state so they switch with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puf_reset  <= 1'b1;
            puf_enable <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            puf_reset  <= (state_next == ST_IDLE) || (state_next == ST_PRST);
            puf_enable <= (state_next == ST_MEAS) || (state_next == ST_SAMPLE);
            busy       <= (state_next != ST_IDLE);
            resp_valid <= (state_next == ST_OUT);
        end
    end

    // Response word: cleared on a new run, one bit written per completed bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_word <= '0;
        end else if (state == ST_IDLE && start) begin
            resp_word <= '0;
        end else if (bit_done) begin
            resp_word[bit_idx] <= bit_val;
        end else begin
            resp_word <= resp_word;
        end
    end

    crp_lfsr #(
        .W    (CHAL_W),
        .SEED (DEF_SEED),
        .TAPS (CHAL_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk        (clk),
        .rst        (reset),
        .load       ((state == ST_IDLE) && seed_load),
        .load_value (seed),
        .advance    (bit_done),
        .value      (chal)
    );

endmodule

// File: tb/tb_ro_crp_sequencer.sv
// Directed self-checking bench for ro_crp_sequencer (small parameters); also
// covers the RO_CRP_MAJORITY_VOTE_EN build when that macro is defined.
module tb_ro_crp_sequencer;

    localparam int          CW  = 34;
    localparam int          RB  = 4;
    localparam int          RC  = 4;
    localparam int          MC  = 16;
    localparam int          SEG = RC + MC + 3;
    localparam logic [33:0] DEF = 34'h2_5A5A_5A5A;
`ifdef RO_CRP_MAJORITY_VOTE_EN
    localparam int NMEAS = 3;
`else
    localparam int NMEAS = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          seed_load;
    logic [CW-1:0] seed;
    logic [CW-1:0] chal;
    logic          puf_reset;
    logic          puf_enable;
    logic          puf_resp;
    logic [RB-1:0] resp_word;
    logic          resp_valid;
    logic          resp_ready;
    logic          busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [33:0] model;

    always #5 clk = ~clk;

    ro_crp_sequencer #(
        .CHAL_W      (CW),
        .RESP_BITS   (RB),
        .MEAS_CYCLES (MC),
        .RST_CYCLES  (RC),
        .DEF_SEED    (DEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .chal       (chal),
        .puf_reset  (puf_reset),
        .puf_enable (puf_enable),
        .puf_resp   (puf_resp),
        .resp_word  (resp_word),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Golden step written straight from x^34+x^27+x^2+x+1.
    function automatic logic [33:0] lfsr_next(input logic [33:0] s);
        return {s[32:0], s[33] ^ s[26] ^ s[1] ^ s[0]};
    endfunction

    // Start one word, optionally with a simultaneous seed load, and walk every phase.
    task automatic run_word(input logic [3:0] pat, input bit noise,
                            input bit with_seed, input logic [33:0] sd);
        logic v;
        @(negedge clk);
        start = 1'b1;
        if (with_seed) begin
            seed_load = 1'b1;
            seed      = sd;
            model     = (sd == 34'd0) ? DEF : sd;
        end
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        for (int b = 0; b < RB; b++) begin
            for (int m = 0; m < NMEAS; m++) begin
                v = (m == 1) ? ~pat[b] : pat[b];
                for (int p = 0; p < SEG; p++) begin
                    if (!(b == 0 && m == 0 && p == 0)) begin
                        @(posedge clk); #1;
                    end
                    if (p == 0) check_eq("chal", {30'd0, chal}, {30'd0, model});
                    if (p == 0 && b == 0 && m == 0) check_eq("busy_run", {63'd0, busy}, 64'd1);
                    if (p == 0 && b == 0 && m == 0) check_eq("prst", {62'd0, puf_enable, puf_reset}, 64'd1);
                    if (p == RC + 1 && b == 0 && m == 0)
                        check_eq("meas", {62'd0, puf_enable, puf_reset}, 64'd2);
                    if (p == RC + MC + 1 && b == 1 && m == 0)
                        check_eq("sample", {62'd0, puf_enable, puf_reset}, 64'd2);
                    if (noise && p >= RC && p < RC + 8) begin
                        #2 puf_resp = ~puf_resp;
                    end
                    if (p == RC + 8) puf_resp = v;
                end
            end
            model = lfsr_next(model);
        end
        check_eq("valid_early", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        check_eq("valid_lat", {63'd0, resp_valid}, 64'd1);
        check_eq("word", {60'd0, resp_word}, {60'd0, pat});
        check_eq("chal_end", {30'd0, chal}, {30'd0, model});
    endtask

    // Hold the word in OUT with stray start pulses, then hand it off.
    task automatic finish_word(input int hold, input logic [3:0] pat);
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start = (i % 7 == 3);
            check_eq("hold_valid", {63'd0, resp_valid}, 64'd1);
            check_eq("hold_word", {60'd0, resp_word}, {60'd0, pat});
        end
        start      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        resp_ready = 1'b0;
        check_eq("ack_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("ack_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check_eq("start_dropped", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int cnt_v;
        reset      = 1'b1;
        start      = 1'b0;
        seed_load  = 1'b0;
        seed       = '0;
        puf_resp   = 1'b1;
        resp_ready = 1'b0;
        model      = DEF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_chal", {30'd0, chal}, {30'd0, DEF});
        check_eq("rst_word", {60'd0, resp_word}, 64'd0);
        check_eq("rst_outs", {60'd0, resp_valid, puf_enable, puf_reset, busy}, 64'h2);
        @(negedge clk);
        reset = 1'b0;

        run_word(4'hF, 1'b0, 1'b0, 34'd0);
        finish_word(50, 4'hF);

        @(negedge clk);
        seed_load = 1'b1;
        seed      = 34'd0;
        @(posedge clk); #1;
        seed_load = 1'b0;
        model     = DEF;
        check_eq("seed_zero", {30'd0, chal}, {30'd0, DEF});

        @(negedge clk);
        seed_load = 1'b1;
        seed      = 34'd1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        model     = 34'd1;
        check_eq("seed_one", {30'd0, chal}, 64'd1);
        run_word(4'b0110, 1'b1, 1'b0, 34'd0);
        finish_word(3, 4'b0110);
        run_word(4'b1001, 1'b1, 1'b0, 34'd0);
        finish_word(3, 4'b1001);

        run_word(4'b0011, 1'b1, 1'b1, 34'h3_C3C3_0001);
        finish_word(2, 4'b0011);

        // Abort in MEAS of bit 2.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (NMEAS * SEG * 2 + RC + 5) @(posedge clk);
        #1;
        check_eq("pre_abort_en", {63'd0, puf_enable}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_outs", {60'd0, resp_valid, puf_enable, puf_reset, busy}, 64'h2);
        check_eq("abort_chal", {30'd0, chal}, {30'd0, DEF});
        check_eq("abort_word", {60'd0, resp_word}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model = DEF;
        cnt_v = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (resp_valid) cnt_v++;
        end
        check_eq("no_partial", 64'(cnt_v), 64'd0);
        run_word(4'b1100, 1'b1, 1'b0, 34'd0);
        finish_word(2, 4'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
